mgmt_gpio_port: RTL and testbench

Management-side endpoint of the user-project GPIO buffer path. It drives `mgmt_gpio_out` and `mgmt_gpio_oeb` from registers, and synchronizes the returning `mgmt_gpio_in_buf` bits. It detects edges on those inputs, latches them into sticky status, and raises a level interrupt. The block sits behind a Wishbone slave port in the management SoC, on the far side of the pad buffer chain from the pads.

---
 rtl/mgmt_gpio_port_pkg.sv | 45 ++++
 rtl/mgmt_gpio_sync.sv | 46 ++++
 rtl/mgmt_gpio_port.sv | 105 ++++++++++
 tb/tb_mgmt_gpio_port.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_gpio_port_pkg.sv
// Shared register offsets, reset constants and address decode helpers for the
// management GPIO port.
package mgmt_gpio_port_pkg;

    localparam logic [7:0] MGMT_GPIO_OUT     = 8'h00;
    localparam logic [7:0] MGMT_GPIO_OEB     = 8'h04;
    localparam logic [7:0] MGMT_GPIO_IN      = 8'h08;
    localparam logic [7:0] MGMT_GPIO_STAT    = 8'h0C;
    localparam logic [7:0] MGMT_GPIO_RISE_EN = 8'h10;
    localparam logic [7:0] MGMT_GPIO_FALL_EN = 8'h14;

    // Outputs come out of reset disabled (OEB is active-low).
    localparam logic [31:0] MGMT_GPIO_OEB_RESET = 32'hFFFF_FFFF;

    localparam int PRIME_W = 2;

    typedef enum logic [2:0] {
        REG_OUT,
        REG_OEB,
        REG_IN,
        REG_STAT,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [7:0] adr);
        reg_sel_e r;
        case ({adr[7:2], 2'b00})
            MGMT_GPIO_OUT:     r = REG_OUT;
            MGMT_GPIO_OEB:     r = REG_OEB;
            MGMT_GPIO_IN:      r = REG_IN;
            MGMT_GPIO_STAT:    r = REG_STAT;
            MGMT_GPIO_RISE_EN: r = REG_RISE_EN;
            MGMT_GPIO_FALL_EN: r = REG_FALL_EN;
            default:           r = REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/mgmt_gpio_sync.sv
// Two-flop synchronizer for the returning pad inputs, followed by a history
// flop and registered edge detection gated by a short priming counter.
module mgmt_gpio_sync #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    import mgmt_gpio_port_pkg::*;

    logic [WIDTH-1:0]   meta;
    logic [WIDTH-1:0]   sync_q;
    logic [WIDTH-1:0]   prev;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;

    assign primed = &prime_cnt;
    assign sync   = sync_q;

    // Edges are held off until the pipeline has filled with real pad values,
    // so pins sitting high through reset never look like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= '0;
            sync_q    <= '0;
            prev      <= '0;
            prime_cnt <= '0;
            rise      <= '0;
            fall      <= '0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            prev   <= sync_q;
            if (!primed) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
            rise <= primed ? (sync_q & ~prev) : '0;
            fall <= primed ? (~sync_q & prev) : '0;
        end
    end

endmodule

// File: rtl/mgmt_gpio_port.sv
// Management-side GPIO endpoint: Wishbone register file driving the pad outputs,
// synchronized input readback, sticky edge status and a level interrupt.
module mgmt_gpio_port #(
    parameter int N_PADS = 19,
    parameter int N_OEB  = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [7:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_PADS-1:0] mgmt_gpio_in_buf,
    output logic [N_PADS-1:0] mgmt_gpio_out,
    output logic [N_OEB-1:0]  mgmt_gpio_oeb,
    output logic              irq
);
    import mgmt_gpio_port_pkg::*;

    logic [N_PADS-1:0] in_sync;
    logic [N_PADS-1:0] in_rise;
    logic [N_PADS-1:0] in_fall;
    logic [N_PADS-1:0] stat;
    logic [N_PADS-1:0] rise_en;
    logic [N_PADS-1:0] fall_en;
    logic [N_PADS-1:0] stat_set;
    logic [N_PADS-1:0] stat_clear;
    logic              accept;
    logic              wr;
    reg_sel_e          reg_sel;
    logic [31:0]       wmask;
    logic [31:0]       wdata_m;
    logic [31:0]       rd_data;

    mgmt_gpio_sync #(
        .WIDTH (N_PADS)
    ) u_sync (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .din  (mgmt_gpio_in_buf),
        .sync (in_sync),
        .rise (in_rise),
        .fall (in_fall)
    );

    // Blocking accept while ack is high spaces back-to-back accesses two cycles apart.
    assign accept  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = accept & wb_we_i;
    assign reg_sel = decode_reg(wb_adr_i);
    assign wmask   = byte_mask(wb_sel_i);
    assign wdata_m = wb_dat_i & wmask;

    assign stat_set   = (in_rise & rise_en) | (in_fall & fall_en);
    assign stat_clear = (wr && reg_sel == REG_STAT) ? wdata_m[N_PADS-1:0] : '0;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_OUT:     rd_data[N_PADS-1:0] = mgmt_gpio_out;
            REG_OEB:     rd_data[N_OEB-1:0]  = mgmt_gpio_oeb;
            REG_IN:      rd_data[N_PADS-1:0] = in_sync;
            REG_STAT:    rd_data[N_PADS-1:0] = stat;
            REG_RISE_EN: rd_data[N_PADS-1:0] = rise_en;
            REG_FALL_EN: rd_data[N_PADS-1:0] = fall_en;
            default:     rd_data = '0;
        endcase
    end

    // A new edge landing in the same cycle as a W1C keeps its bit set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o      <= 1'b0;
            wb_dat_o      <= '0;
            mgmt_gpio_out <= '0;
            mgmt_gpio_oeb <= MGMT_GPIO_OEB_RESET[N_OEB-1:0];
            rise_en       <= '0;
            fall_en       <= '0;
            stat          <= '0;
            irq           <= 1'b0;
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= accept ? rd_data : '0;
            if (wr) begin
                case (reg_sel)
                    REG_OUT:     mgmt_gpio_out <= (mgmt_gpio_out & ~wmask[N_PADS-1:0])
                                                  | wdata_m[N_PADS-1:0];
                    REG_OEB:     mgmt_gpio_oeb <= (mgmt_gpio_oeb & ~wmask[N_OEB-1:0])
                                                  | wdata_m[N_OEB-1:0];
                    REG_RISE_EN: rise_en <= (rise_en & ~wmask[N_PADS-1:0])
                                            | wdata_m[N_PADS-1:0];
                    REG_FALL_EN: fall_en <= (fall_en & ~wmask[N_PADS-1:0])
                                            | wdata_m[N_PADS-1:0];
                    default: ;
                endcase
            end
            stat <= (stat & ~stat_clear) | stat_set;
            irq  <= |stat;
        end
    end

endmodule

// File: tb/tb_mgmt_gpio_port.sv
// Directed bench for mgmt_gpio_port: register access, byte enables, edge status,
// W1C/edge collision, ack spacing and reset during a pending access.
module tb_mgmt_gpio_port;

    localparam int N_PADS = 19;
    localparam int N_OEB  = 3;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [3:0]        wb_sel_i;
    logic [7:0]        wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic [N_PADS-1:0] mgmt_gpio_in_buf;
    logic [N_PADS-1:0] mgmt_gpio_out;
    logic [N_OEB-1:0]  mgmt_gpio_oeb;
    logic              irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdata;

    always #5 wb_clk_i = ~wb_clk_i;

    mgmt_gpio_port #(
        .N_PADS (N_PADS),
        .N_OEB  (N_OEB)
    ) dut (
        .wb_clk_i         (wb_clk_i),
        .wb_rst_i         (wb_rst_i),
        .wb_cyc_i         (wb_cyc_i),
        .wb_stb_i         (wb_stb_i),
        .wb_we_i          (wb_we_i),
        .wb_sel_i         (wb_sel_i),
        .wb_adr_i         (wb_adr_i),
        .wb_dat_i         (wb_dat_i),
        .wb_dat_o         (wb_dat_o),
        .wb_ack_o         (wb_ack_o),
        .mgmt_gpio_in_buf (mgmt_gpio_in_buf),
        .mgmt_gpio_out    (mgmt_gpio_out),
        .mgmt_gpio_oeb    (mgmt_gpio_oeb),
        .irq              (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge where ack is seen.
    task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [31:0] data,
                                 input logic [3:0] sel, output logic [31:0] rd);
        logic seen;
        seen     = 1'b0;
        rd       = '0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = data;
        wb_sel_i = sel;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge wb_clk_i);
            if (wb_ack_o) begin
                seen = 1'b1;
                rd   = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        checkOutput("ack_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic writeReg(input logic [7:0] adr, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] unused;
        applyStimulus(1'b1, adr, data, sel, unused);
    endtask

    task automatic readReg(input string tag, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        applyStimulus(1'b0, adr, 32'd0, 4'hF, rd);
        checkOutput(tag, rd, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acks;
        int consec;
        logic prev_ack;

        wb_rst_i         = 1'b1;
        wb_cyc_i         = 1'b0;
        wb_stb_i         = 1'b0;
        wb_we_i          = 1'b0;
        wb_sel_i         = 4'h0;
        wb_adr_i         = 8'h00;
        wb_dat_i         = 32'h0;
        mgmt_gpio_in_buf = '1;
        repeat (3) @(negedge wb_clk_i);
        checkOutput("rst_out", mgmt_gpio_out, 32'h0);
        checkOutput("rst_oeb", mgmt_gpio_oeb, 32'h7);
        checkOutput("rst_ack", wb_ack_o, 32'h0);
        checkOutput("rst_dat", wb_dat_o, 32'h0);
        checkOutput("rst_irq", irq, 32'h0);

        wb_rst_i = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        readReg("rd_out0", 8'h00, 32'h0);
        readReg("rd_oeb0", 8'h04, 32'h7);
        readReg("rd_in_high", 8'h08, 32'h7FFFF);
        readReg("rd_stat0", 8'h0C, 32'h0);
        readReg("rd_rise0", 8'h10, 32'h0);
        readReg("rd_fall0", 8'h14, 32'h0);
        checkOutput("irq_idle", irq, 32'h0);

        mgmt_gpio_in_buf = '0;
        repeat (6) @(negedge wb_clk_i);
        readReg("stat_fall_disabled", 8'h0C, 32'h0);
        readReg("rd_in_low", 8'h08, 32'h0);

        writeReg(8'h00, 32'h0005A5A5, 4'hF);
        checkOutput("out_full", mgmt_gpio_out, 32'h5A5A5);
        writeReg(8'h00, 32'hFFFFFFFF, 4'h1);
        checkOutput("out_byte0", mgmt_gpio_out, 32'h5A5FF);
        readReg("rd_out_byte0", 8'h00, 32'h5A5FF);
        @(negedge wb_clk_i);
        checkOutput("dat_idle", wb_dat_o, 32'h0);

        writeReg(8'h04, 32'h2, 4'hF);
        checkOutput("oeb_write", mgmt_gpio_oeb, 32'h2);
        writeReg(8'h08, 32'hFFFF, 4'hF);
        readReg("in_ro", 8'h08, 32'h0);
        writeReg(8'h40, 32'hFFFF, 4'hF);
        readReg("unmapped", 8'h40, 32'h0);

        // Rising edge on pin 4: STAT at E+3, irq at E+4.
        writeReg(8'h10, 32'h10, 4'hF);
        repeat (2) @(negedge wb_clk_i);
        mgmt_gpio_in_buf[4] = 1'b1;
        repeat (4) @(negedge wb_clk_i);
        checkOutput("irq_e3", irq, 32'h0);
        @(negedge wb_clk_i);
        checkOutput("irq_e4", irq, 32'h1);
        readReg("stat_rise4", 8'h0C, 32'h10);

        mgmt_gpio_in_buf[4] = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        readReg("stat_fall_ignored", 8'h0C, 32'h10);

        writeReg(8'h0C, 32'h10, 4'hF);
        checkOutput("irq_clr_t1", irq, 32'h1);
        @(negedge wb_clk_i);
        checkOutput("irq_clr_t2", irq, 32'h0);
        readReg("stat_cleared", 8'h0C, 32'h0);

        // Re-arm, then collide a W1C with a fresh rising edge.
        mgmt_gpio_in_buf[4] = 1'b1;
        repeat (6) @(negedge wb_clk_i);
        mgmt_gpio_in_buf[4] = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        checkOutput("irq_rearmed", irq, 32'h1);
        mgmt_gpio_in_buf[4] = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        writeReg(8'h0C, 32'h10, 4'hF);
        for (int i = 0; i < 3; i++) begin
            checkOutput("irq_collide", irq, 32'h1);
            @(negedge wb_clk_i);
        end
        readReg("stat_collide", 8'h0C, 32'h10);

        writeReg(8'h0C, 32'h10, 4'hF);
        writeReg(8'h10, 32'h0, 4'hF);
        writeReg(8'h14, 32'h10, 4'hF);
        mgmt_gpio_in_buf[4] = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        readReg("stat_fall4", 8'h0C, 32'h10);
        readReg("rd_fall_en", 8'h14, 32'h10);

        repeat (2) @(negedge wb_clk_i);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 8'h00;
        acks     = 0;
        consec   = 0;
        prev_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            if (wb_ack_o) acks++;
            if (wb_ack_o && prev_ack) consec++;
            prev_ack = wb_ack_o;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        checkOutput("held_stb_acks", acks, 32'd3);
        checkOutput("held_stb_consec", consec, 32'd0);

        repeat (2) @(negedge wb_clk_i);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 8'h04;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'hF;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("rstmid_ack", wb_ack_o, 32'h0);
        checkOutput("rstmid_oeb", mgmt_gpio_oeb, 32'h7);
        checkOutput("rstmid_out", mgmt_gpio_out, 32'h0);
        wb_rst_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("rstmid_lost", wb_ack_o, 32'h0);
        checkOutput("rstmid_oeb_hold", mgmt_gpio_oeb, 32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
